// File: rtl/hv_dac_multi_fsm_pkg.sv
// Shared types and helpers for the multi-channel HV DAC update sequencer.
// Holds the sequencer state enum, the clog2 helper and the derived sizing
// (frame length, frame-counter width). Modules derive their own sizing from
// their parameters through the helper functions; the localparams here give
// the values for the default configuration.
package hv_dac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_SHIFT,
    ST_CFG_GAP,
    ST_FR_SHIFT,
    ST_FR_GAP,
    ST_LOAD,
    ST_DONE
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Frame counter width, at least one bit.
  function automatic int unsigned fcnt_w(input int unsigned n_ch);
    return (clog2(n_ch) == 0) ? 1 : clog2(n_ch);
  endfunction

  // CLK cycles per frame: shift phase plus inter-frame gap.
  function automatic int unsigned frame_cyc(input int unsigned div,
                                            input int unsigned word_w,
                                            input int unsigned gap_cyc);
    return 2 * div * word_w + gap_cyc;
  endfunction

  localparam int unsigned DEF_N_CH    = 8;
  localparam int unsigned DEF_WORD_W  = 16;
  localparam int unsigned DEF_DIV     = 1;
  localparam int unsigned DEF_GAP_CYC = 2;

  localparam int unsigned FRAME_CYC = frame_cyc(DEF_DIV, DEF_WORD_W, DEF_GAP_CYC);
  localparam int unsigned FCNT_W    = fcnt_w(DEF_N_CH);

endpackage

// File: rtl/hv_dac_multi_fsm_if.sv
// Bus between the HV slow-control register file and the DAC sequencer.
// master: register-file side (drives request, words, DAC readback).
// slave : sequencer side (drives DAC pins and status).
interface hv_dac_multi_fsm_if #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned WORD_W = 16
);
  import hv_dac_pkg::*;

  localparam int unsigned FCNT_W = fcnt_w(N_CH);

  logic                     hv_start;
  logic                     abort;
  logic [WORD_W-1:0]        cfg_word;
  logic [N_CH*WORD_W-1:0]   hv_data;
  logic                     dac_err;

  logic                     dac_cs_n;
  logic                     dac_sclk;
  logic                     dac_sdi;
  logic                     dac_ld_n;
  logic                     busy;
  logic                     done;
  logic [N_CH-1:0]          dac_err_reg;
  logic [FCNT_W-1:0]        f_cnt;

  modport master (
    output hv_start, abort, cfg_word, hv_data, dac_err,
    input  dac_cs_n, dac_sclk, dac_sdi, dac_ld_n, busy, done, dac_err_reg, f_cnt
  );

  modport slave (
    input  hv_start, abort, cfg_word, hv_data, dac_err,
    output dac_cs_n, dac_sclk, dac_sdi, dac_ld_n, busy, done, dac_err_reg, f_cnt
  );

endinterface

// File: rtl/hv_dac_multi_fsm_serializer.sv
// One-frame SPI-style serializer.
// Ports: CLK, reset (async active-low); load + word start a frame, clear
// aborts it; cs_n/sclk/sdi are registered pin outputs; last_c is high during
// the final cycle of the shift phase (last sclk-high half of bit 0).
// Each bit is sdi-stable with sclk low for DIV cycles, then sclk high for
// DIV cycles, MSB first. The word is held internally, so it doubles as the
// shadow copy of the frame being sent.
module hv_dac_serializer
  import hv_dac_pkg::*;
#(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned DIV    = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [WORD_W-1:0] word,
  output logic              cs_n,
  output logic              sclk,
  output logic              sdi,
  output logic              last_c
);

  localparam int unsigned DCW = (clog2(DIV) == 0) ? 1 : clog2(DIV);
  localparam int unsigned BCW = clog2(WORD_W);

  logic              active_q, active_d;
  logic              cs_n_q,   cs_n_d;
  logic              sclk_q,   sclk_d;
  logic              sdi_q,    sdi_d;
  logic [WORD_W-1:0] sh_q,     sh_d;
  logic [BCW-1:0]    bit_q,    bit_d;
  logic [DCW-1:0]    div_q,    div_d;
  logic              phase_end;

  // Bit/phase sequencing.
  always_comb begin
    active_d  = active_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    sdi_d     = sdi_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    div_d     = div_q;
    phase_end = active_q && (div_q == DCW'(DIV - 1));
    last_c    = phase_end && sclk_q && (bit_q == '0);

    if (clear) begin
      active_d = 1'b0;
      cs_n_d   = 1'b1;
      sclk_d   = 1'b0;
      sdi_d    = 1'b0;
      div_d    = '0;
    end else if (load) begin
      active_d = 1'b1;
      cs_n_d   = 1'b0;
      sclk_d   = 1'b0;
      sh_d     = word;
      sdi_d    = word[WORD_W-1];
      bit_d    = BCW'(WORD_W - 1);
      div_d    = '0;
    end else if (active_q) begin
      if (phase_end) begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else if (bit_q == '0) begin
          active_d = 1'b0;
          cs_n_d   = 1'b1;
          sclk_d   = 1'b0;
          sdi_d    = 1'b0;
        end else begin
          // sdi advances together with the falling sclk edge
          sclk_d = 1'b0;
          bit_d  = bit_q - 1'b1;
          sdi_d  = sh_q[bit_d];
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      sdi_q    <= 1'b0;
      sh_q     <= '0;
      bit_q    <= '0;
      div_q    <= '0;
    end else begin
      active_q <= active_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      sdi_q    <= sdi_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
    end
  end

  assign cs_n = cs_n_q;
  assign sclk = sclk_q;
  assign sdi  = sdi_q;

endmodule

// File: rtl/hv_dac_multi_fsm.sv
// Multi-channel HV DAC update sequencer.
// Ports: CLK, reset (async active-low), bus (slave modport) carrying
// hv_start/abort/cfg_word/hv_data/dac_err in and the DAC pins
// (dac_cs_n/dac_sclk/dac_sdi/dac_ld_n) plus busy/done/dac_err_reg/f_cnt out.
// An update sends an optional cfg preamble frame and N_CH channel frames,
// captures dac_err after every channel frame, pulses ld_n, then signals done.
module hv_dac_multi_fsm
  import hv_dac_pkg::*;
#(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned DIV     = 1,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned LD_CYC  = 2,
  parameter int unsigned CFG_EN  = 1
) (
  input  logic               CLK,
  input  logic               reset,
  hv_dac_multi_fsm_if.slave  bus
);

  localparam int unsigned FW      = fcnt_w(N_CH);
  localparam int unsigned CNT_MAX = (GAP_CYC > LD_CYC) ? GAP_CYC : LD_CYC;
  localparam int unsigned CW      = (clog2(CNT_MAX) == 0) ? 1 : clog2(CNT_MAX);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [FW-1:0]     f_q,     f_d;
  logic [N_CH-1:0]   err_q,   err_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              ld_n_q,  ld_n_d;
  logic [WORD_W-1:0] ch_q [N_CH];
  logic [WORD_W-1:0] ch_d [N_CH];

  logic              ser_load;
  logic              ser_clear;
  logic              ser_last;
  logic [WORD_W-1:0] ser_word;
  logic [FW-1:0]     f_nxt;

  // Next-state, shadow capture and frame sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f_d       = f_q;
    err_d     = err_q;
    ch_d      = ch_q;
    ser_load  = 1'b0;
    ser_clear = 1'b0;
    ser_word  = '0;
    f_nxt     = f_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.hv_start && !bus.abort) begin
          for (int unsigned k = 0; k < N_CH; k++) begin
            ch_d[k] = bus.hv_data[k*WORD_W +: WORD_W];
          end
          err_d    = '0;
          f_d      = '0;
          cnt_d    = '0;
          ser_load = 1'b1;
          if (CFG_EN != 0) begin
            ser_word = bus.cfg_word;
            state_d  = ST_CFG_SHIFT;
          end else begin
            ser_word = bus.hv_data[WORD_W-1:0];
            state_d  = ST_FR_SHIFT;
          end
        end
      end
      ST_CFG_SHIFT: begin
        if (ser_last) begin
          cnt_d   = '0;
          state_d = ST_CFG_GAP;
        end
      end
      ST_CFG_GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          ser_load = 1'b1;
          ser_word = ch_q[0];
          state_d  = ST_FR_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FR_SHIFT: begin
        if (ser_last) begin
          cnt_d   = '0;
          state_d = ST_FR_GAP;
        end
      end
      ST_FR_GAP: begin
        // readback belongs to the frame that just closed
        if (cnt_q == '0) err_d[f_q] = bus.dac_err;
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          cnt_d = '0;
          if (f_q == FW'(N_CH - 1)) begin
            state_d = ST_LOAD;
          end else begin
            f_d      = f_nxt;
            ser_load = 1'b1;
            ser_word = ch_q[f_nxt];
            state_d  = ST_FR_SHIFT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        if (cnt_q == CW'(LD_CYC - 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        f_d     = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // abort overrides everything outside IDLE; captured error bits survive
    if ((state_q != ST_IDLE) && bus.abort) begin
      state_d   = ST_IDLE;
      f_d       = '0;
      cnt_d     = '0;
      ser_load  = 1'b0;
      ser_clear = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    ld_n_d = (state_d != ST_LOAD);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      f_q     <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ld_n_q  <= 1'b1;
      for (int unsigned k = 0; k < N_CH; k++) ch_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ld_n_q  <= ld_n_d;
      ch_q    <= ch_d;
    end
  end

  hv_dac_serializer #(
    .WORD_W (WORD_W),
    .DIV    (DIV)
  ) u_ser (
    .CLK    (CLK),
    .reset  (reset),
    .load   (ser_load),
    .clear  (ser_clear),
    .word   (ser_word),
    .cs_n   (bus.dac_cs_n),
    .sclk   (bus.dac_sclk),
    .sdi    (bus.dac_sdi),
    .last_c (ser_last)
  );

  assign bus.dac_ld_n    = ld_n_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.dac_err_reg = err_q;
  assign bus.f_cnt       = f_q;

endmodule

// File: tb/tb_hv_dac_multi_fsm.sv
// Directed bench for hv_dac_multi_fsm: default build (dut_a) and a
// CFG_EN=0 / DIV=2 / N_CH=4 / WORD_W=12 build (dut_b).
module tb_hv_dac_multi_fsm;
  import hv_dac_pkg::*;

  logic CLK   = 1'b0;
  logic reset = 1'b0;
  always #5 CLK = ~CLK;

  hv_dac_multi_fsm_if #(.N_CH(8), .WORD_W(16)) ifa ();
  hv_dac_multi_fsm_if #(.N_CH(4), .WORD_W(12)) ifb ();

  hv_dac_multi_fsm dut_a (.CLK(CLK), .reset(reset), .bus(ifa.slave));

  hv_dac_multi_fsm #(
    .N_CH(4), .WORD_W(12), .DIV(2), .GAP_CYC(2), .LD_CYC(2), .CFG_EN(0)
  ) dut_b (.CLK(CLK), .reset(reset), .bus(ifb.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // run configuration
  int sel, hold, err_mode, abort_cyc, chg_cyc, rst_cyc;
  logic cur_start, cur_abort, cur_err;

  // observed outputs of the selected DUT
  logic       o_cs, o_sclk, o_sdi, o_ld, o_busy, o_done;
  logic [7:0] o_err, o_f;

  // serial decode / timing tracker
  logic        p_cs, p_sclk;
  logic [15:0] sh;
  int          win, ld_low, ld_first, sclk_hi, done_cyc;
  logic        busy1;
  logic [15:0] words[$];
  int          wins[$];

  task automatic apply();
    if (sel == 0) begin
      ifa.hv_start = cur_start; ifa.abort = cur_abort; ifa.dac_err = cur_err;
    end else begin
      ifb.hv_start = cur_start; ifb.abort = cur_abort; ifb.dac_err = cur_err;
    end
  endtask

  task automatic sample();
    if (sel == 0) begin
      o_cs = ifa.dac_cs_n; o_sclk = ifa.dac_sclk; o_sdi = ifa.dac_sdi;
      o_ld = ifa.dac_ld_n; o_busy = ifa.busy;     o_done = ifa.done;
      o_err = ifa.dac_err_reg; o_f = 8'(ifa.f_cnt);
    end else begin
      o_cs = ifb.dac_cs_n; o_sclk = ifb.dac_sclk; o_sdi = ifb.dac_sdi;
      o_ld = ifb.dac_ld_n; o_busy = ifb.busy;     o_done = ifb.done;
      o_err = 8'(ifb.dac_err_reg); o_f = 8'(ifb.f_cnt);
    end
  endtask

  task automatic trk_clear();
    p_cs = 1'b1; p_sclk = 1'b0; sh = '0; win = 0; ld_low = 0; ld_first = -1;
    sclk_hi = 0; done_cyc = -1; busy1 = 1'b0;
    words.delete(); wins.delete();
  endtask

  task automatic track(input int cyc);
    if (!o_cs) begin
      win++;
      if (o_sclk && !p_sclk) sh = {sh[14:0], o_sdi};
      if (o_sclk) sclk_hi++;
    end
    if (o_cs && !p_cs) begin
      words.push_back(sh);
      wins.push_back(win);
      win = 0;
      sh  = '0;
    end
    if (!o_ld) begin
      ld_low++;
      if (ld_first < 0) ld_first = cyc;
    end
    p_cs   = o_cs;
    p_sclk = o_sclk;
  endtask

  // dac_err driven high in the FR_GAP cycles of chosen channels (default build)
  function automatic logic err_at(input int mode, input int cyc);
    case (mode)
      1:       return cyc inside {135, 136, 305, 306};  // channels 2, 7
      2:       return cyc inside {67, 68, 135, 136};    // channels 0, 2
      default: return 1'b0;
    endcase
  endfunction

  task automatic load_a(input logic [15:0] base);
    for (int k = 0; k < 8; k++) ifa.hv_data[k*16 +: 16] = base + 16'(k);
  endtask

  // Cycle 0 is the cycle ending at the first posedge after this task starts.
  task automatic run_update(input int limit);
    trk_clear();
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge CLK);
      sample();
      track(cyc);
      if (cyc == 1) begin
        busy1 = o_busy;
        if (hold == 0) cur_start = 1'b0;
      end
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        check("abort_fcnt_before", 32'(o_f), 32'd3);
        cur_abort = 1'b1;
      end
      if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
        cur_abort = 1'b0;
        check("abort_cs_n",  32'(o_cs),   32'd1);
        check("abort_sclk",  32'(o_sclk), 32'd0);
        check("abort_sdi",   32'(o_sdi),  32'd0);
        check("abort_ld_n",  32'(o_ld),   32'd1);
        check("abort_busy",  32'(o_busy), 32'd0);
        check("abort_fcnt",  32'(o_f),    32'd0);
        check("abort_err",   32'(o_err),  32'h05);
      end
      if (cyc == chg_cyc) load_a(16'h2000);
      if (cyc == rst_cyc) begin
        check("pre_rst_ld_n", 32'(o_ld),  32'd0);
        check("pre_rst_err",  32'(o_err), 32'h05);
        #2 reset = 1'b0;
        #1;
        check("rst_ld_n", 32'(ifa.dac_ld_n),    32'd1);
        check("rst_cs_n", 32'(ifa.dac_cs_n),    32'd1);
        check("rst_busy", 32'(ifa.busy),        32'd0);
        check("rst_err",  32'(ifa.dac_err_reg), 32'd0);
        @(negedge CLK);
        reset     = 1'b1;
        cur_start = 1'b0;
        cur_err   = 1'b0;
        apply();
        break;
      end
      cur_err = err_at(err_mode, cyc);
      apply();
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
    end
    cur_err = 1'b0;
    apply();
  endtask

  task automatic start_run(input int limit);
    @(negedge CLK);
    cur_start = 1'b1;
    apply();
    run_update(limit);
  endtask

  task automatic check_windows(input string tag, input int n, input int len);
    int bad;
    bad = 0;
    foreach (wins[i]) if (wins[i] != len) bad++;
    check({tag, "_win_cnt"}, 32'(wins.size()), 32'(n));
    check({tag, "_win_len_bad"}, 32'(bad), 32'd0);
  endtask

  logic [15:0] exp_w [9];

  initial begin
    ifa.hv_start = 0; ifa.abort = 0; ifa.dac_err = 0; ifa.cfg_word = '0; ifa.hv_data = '0;
    ifb.hv_start = 0; ifb.abort = 0; ifb.dac_err = 0; ifb.cfg_word = '0; ifb.hv_data = '0;
    cur_start = 0; cur_abort = 0; cur_err = 0;
    sel = 0; hold = 0; err_mode = 0; abort_cyc = -1; chg_cyc = -1; rst_cyc = -1;

    // reset values
    repeat (3) @(negedge CLK);
    sample();
    check("rst0_cs_n", 32'(o_cs),   32'd1);
    check("rst0_sclk", 32'(o_sclk), 32'd0);
    check("rst0_sdi",  32'(o_sdi),  32'd0);
    check("rst0_ld_n", 32'(o_ld),   32'd1);
    check("rst0_busy", 32'(o_busy), 32'd0);
    check("rst0_done", 32'(o_done), 32'd0);
    check("rst0_err",  32'(o_err),  32'd0);
    check("rst0_fcnt", 32'(o_f),    32'd0);
    reset = 1'b1;
    repeat (2) @(negedge CLK);

    // T1: default build, cfg A5A5 + channels 1000..1007
    ifa.cfg_word = 16'hA5A5;
    load_a(16'h1000);
    exp_w[0] = 16'hA5A5;
    for (int k = 0; k < 8; k++) exp_w[k+1] = 16'h1000 + 16'(k);
    start_run(400);
    check("t1_busy_c1",  32'(busy1),    32'd1);
    check("t1_done_cyc", 32'(done_cyc), 32'd309);
    check("t1_words_n",  32'(words.size()), 32'd9);
    for (int i = 0; i < words.size() && i < 9; i++)
      check($sformatf("t1_word%0d", i), 32'(words[i]), 32'(exp_w[i]));
    check_windows("t1", 9, 32);
    check("t1_ld_low",   32'(ld_low),   32'd2);
    check("t1_ld_first", 32'(ld_first), 32'd307);
    check("t1_err",      32'(o_err),    32'h00);
    @(negedge CLK);
    sample();
    check("t1_idle_busy", 32'(o_busy), 32'd0);
    check("t1_idle_done", 32'(o_done), 32'd0);
    check("t1_idle_fcnt", 32'(o_f),    32'd0);
    repeat (2) @(negedge CLK);

    // T2: dac_err during FR_GAP of channels 2 and 7
    err_mode = 1;
    start_run(400);
    check("t2_done_cyc", 32'(done_cyc), 32'd309);
    check("t2_err",      32'(o_err),    32'h84);
    err_mode = 0;
    repeat (2) @(negedge CLK);

    // T3: CFG_EN=0, DIV=2, N_CH=4, WORD_W=12
    sel = 1;
    ifb.cfg_word = 12'hFFF;
    ifb.hv_data  = {12'h001, 12'h800, 12'h123, 12'hABC};
    start_run(400);
    check("t3_done_cyc", 32'(done_cyc), 32'd203);
    check("t3_words_n",  32'(words.size()), 32'd4);
    if (words.size() == 4) begin
      check("t3_word0", 32'(words[0]), 32'h0ABC);
      check("t3_word1", 32'(words[1]), 32'h0123);
      check("t3_word2", 32'(words[2]), 32'h0800);
      check("t3_word3", 32'(words[3]), 32'h0001);
    end
    check_windows("t3", 4, 48);
    check("t3_sclk_hi", 32'(sclk_hi), 32'd96);
    check("t3_ld_low",  32'(ld_low),  32'd2);
    check("t3_err",     32'(o_err),   32'd0);
    sel = 0;
    repeat (2) @(negedge CLK);

    // T4: abort during channel 3 frame, bit 5 (cycle 157)
    err_mode  = 2;
    abort_cyc = 157;
    start_run(500);
    check("t4_no_done", 32'(done_cyc == -1), 32'd1);
    check("t4_no_ld",   32'(ld_low),         32'd0);
    check("t4_err_end", 32'(o_err),          32'h05);
    abort_cyc = -1;
    err_mode  = 0;
    repeat (2) @(negedge CLK);

    // T5: hv_start held; hv_data changed mid-update reaches only the second update
    load_a(16'h1000);
    hold    = 1;
    chg_cyc = 50;
    start_run(400);
    check("t5a_done_cyc", 32'(done_cyc), 32'd309);
    if (words.size() == 9) begin
      check("t5a_word1", 32'(words[1]), 32'h1000);
      check("t5a_word8", 32'(words[8]), 32'h1007);
    end else check("t5a_words_n", 32'(words.size()), 32'd9);
    @(negedge CLK);
    sample();
    check("t5_gap_busy", 32'(o_busy), 32'd0);
    check("t5_gap_cs_n", 32'(o_cs),   32'd1);
    hold    = 0;
    chg_cyc = -1;
    run_update(400);
    check("t5b_busy_c1",  32'(busy1),    32'd1);
    check("t5b_done_cyc", 32'(done_cyc), 32'd309);
    if (words.size() == 9) begin
      check("t5b_word1", 32'(words[1]), 32'h2000);
      check("t5b_word8", 32'(words[8]), 32'h2007);
    end else check("t5b_words_n", 32'(words.size()), 32'd9);
    repeat (2) @(negedge CLK);

    // T6: async reset during LOAD
    err_mode = 2;
    rst_cyc  = 307;
    start_run(400);
    check("t6_no_done", 32'(done_cyc == -1), 32'd1);
    rst_cyc  = -1;
    err_mode = 0;
    repeat (2) @(negedge CLK);
    sample();
    check("t6_after_busy", 32'(o_busy), 32'd0);
    check("t6_after_ld_n", 32'(o_ld),   32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
